// File: rtl/ifetch_warp_pc_sched_pkg.sv
// Shared types and constants for the per-warp fetch PC scheduler.
// Holds warp state encodings, counter width and set-index slice helpers.
package ifetch_warp_pc_sched_pkg;

   typedef enum logic {
      WARP_READY = 1'b0,
      WARP_WAIT  = 1'b1
   } warp_state_e;

   localparam int IFETCH_PERF_CNT_W = 32;

   // Bit positions of the icache set index inside a fetch PC.
   function automatic int set_idx_lsb(input int line_offset_bits);
      return line_offset_bits;
   endfunction

   function automatic int set_idx_msb(input int line_offset_bits, input int set_bits);
      return line_offset_bits + set_bits - 1;
   endfunction

endpackage

// File: rtl/ifetch_warp_pc_sched_slot.sv
// One warp's fetch PC and READY/WAIT state with the prioritised update:
// rollback > miss > fire > hold, plus wake from WAIT.
module ifetch_warp_slot
   import ifetch_warp_pc_sched_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    INSTR_BYTES = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rollback_hit_i,
   input  logic [ADDR_WIDTH-1:0] rollback_pc_i,
   input  logic                  miss_hit_i,
   input  logic                  miss_sleep_i,
   input  logic [ADDR_WIDTH-1:0] miss_pc_i,
   input  logic                  wake_i,
   input  logic                  fire_i,
   output logic [ADDR_WIDTH-1:0] pc_o,
   output warp_state_e           state_o
);

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   warp_state_e           state_q, state_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         state_q <= WARP_READY;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
      end
   end

   always_comb begin
      pc_d    = pc_q;
      state_d = state_q;
      if (rollback_hit_i) begin
         pc_d    = rollback_pc_i;
         state_d = WARP_READY;
      end else if (miss_hit_i) begin
         pc_d = miss_pc_i;
         // A sleep-miss wins over a same-cycle wake; a near-miss does not.
         if (miss_sleep_i) begin
            state_d = WARP_WAIT;
         end else if (wake_i && state_q == WARP_WAIT) begin
            state_d = WARP_READY;
         end
      end else begin
         if (fire_i) begin
            pc_d = pc_q + ADDR_WIDTH'(INSTR_BYTES);
         end
         if (wake_i && state_q == WARP_WAIT) begin
            state_d = WARP_READY;
         end
      end
   end

   assign pc_o    = pc_q;
   assign state_o = state_q;

endmodule

// File: rtl/ifetch_warp_pc_sched.sv
// Round-robin per-warp fetch PC scheduler feeding the ifetch data stage.
// Optional per-warp perf counters are built only with IFETCH_PERF_CNT_EN defined.
module ifetch_warp_pc_sched
   import ifetch_warp_pc_sched_pkg::*;
#(
   parameter int                    NUM_WARPS        = 4,
   parameter int                    ADDR_WIDTH       = 32,
   parameter int                    LINE_OFFSET_BITS = 6,
   parameter int                    SET_BITS         = 6,
   parameter int                    INSTR_BYTES      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC         = '0,
   localparam int                   WARP_IDX_W       = $clog2(NUM_WARPS)
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_WARPS-1:0]                  warp_en,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [ADDR_WIDTH-1:0]                 out_pc,
   output logic [WARP_IDX_W-1:0]                 out_warp_idx,
   output logic                                  icache_fetch_en,
   output logic [SET_BITS-1:0]                   icache_set_idx,
   input  logic                                  miss_en,
   input  logic                                  miss_sleep,
   input  logic [WARP_IDX_W-1:0]                 miss_warp_idx,
   input  logic [ADDR_WIDTH-1:0]                 miss_pc,
   input  logic [NUM_WARPS-1:0]                  wake_bitmap,
   input  logic                                  rollback_en,
   input  logic [WARP_IDX_W-1:0]                 rollback_warp_idx,
   input  logic [ADDR_WIDTH-1:0]                 rollback_pc,
   output logic [NUM_WARPS-1:0]                  wait_bitmap,
   output logic [NUM_WARPS*IFETCH_PERF_CNT_W-1:0] perf_fetch_cnt,
   output logic [NUM_WARPS*IFETCH_PERF_CNT_W-1:0] perf_miss_cnt
);

   localparam int SET_LSB = set_idx_lsb(LINE_OFFSET_BITS);
   localparam int SET_MSB = set_idx_msb(LINE_OFFSET_BITS, SET_BITS);

   // Handshake: out_valid/out_pc/out_warp_idx are a combinational offer; a
   // transfer (fire) happens in any cycle with out_valid & out_ready, and the
   // offer is held stable while out_ready is low unless eligibility changes.

   logic [WARP_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [NUM_WARPS-1:0]  eligible;
   logic [NUM_WARPS-1:0]  miss_hit;
   logic [NUM_WARPS-1:0]  rollback_hit;
   logic [NUM_WARPS-1:0]  fire_oh;
   logic [WARP_IDX_W-1:0] sel_idx;
   logic [WARP_IDX_W-1:0] cand;
   logic                  sel_found;
   logic                  fire;
   logic [ADDR_WIDTH-1:0] slot_pc    [NUM_WARPS];
   warp_state_e           slot_state [NUM_WARPS];

   always_comb begin
      miss_hit     = '0;
      rollback_hit = '0;
      eligible     = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         miss_hit[w]     = miss_en && (miss_warp_idx == WARP_IDX_W'(w));
         rollback_hit[w] = rollback_en && (rollback_warp_idx == WARP_IDX_W'(w));
         eligible[w]     = !rst && warp_en[w] && (slot_state[w] == WARP_READY)
                           && !miss_hit[w] && !rollback_hit[w];
      end
   end

   // Rotating-priority pick: first eligible warp at or above the pointer.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = rr_ptr_q;
      cand      = rr_ptr_q;
      for (int i = 0; i < NUM_WARPS; i++) begin
         cand = rr_ptr_q + WARP_IDX_W'(i);
         if (!sel_found && eligible[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   assign out_valid       = sel_found;
   assign fire            = sel_found && out_ready;
   assign out_warp_idx    = sel_idx;
   assign out_pc          = slot_pc[sel_idx];
   assign icache_fetch_en = fire;
   assign icache_set_idx  = out_pc[SET_MSB:SET_LSB];

   always_comb begin
      fire_oh = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         fire_oh[w] = fire && (sel_idx == WARP_IDX_W'(w));
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (fire) begin
         rr_ptr_d = sel_idx + WARP_IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

   for (genvar w = 0; w < NUM_WARPS; w++) begin : g_slot
      ifetch_warp_slot #(
         .ADDR_WIDTH  (ADDR_WIDTH),
         .INSTR_BYTES (INSTR_BYTES),
         .RESET_PC    (RESET_PC)
      ) u_slot (
         .clk            (clk),
         .rst            (rst),
         .rollback_hit_i (rollback_hit[w]),
         .rollback_pc_i  (rollback_pc),
         .miss_hit_i     (miss_hit[w]),
         .miss_sleep_i   (miss_sleep),
         .miss_pc_i      (miss_pc),
         .wake_i         (wake_bitmap[w]),
         .fire_i         (fire_oh[w]),
         .pc_o           (slot_pc[w]),
         .state_o        (slot_state[w])
      );
      assign wait_bitmap[w] = (slot_state[w] == WARP_WAIT);
   end

`ifdef IFETCH_PERF_CNT_EN
   for (genvar w = 0; w < NUM_WARPS; w++) begin : g_perf
      logic [IFETCH_PERF_CNT_W-1:0] fetch_cnt_q;
      logic [IFETCH_PERF_CNT_W-1:0] miss_cnt_q;

      // Rollback deliberately leaves these alone; only reset clears them.
      always_ff @(posedge clk) begin
         if (rst) begin
            fetch_cnt_q <= '0;
            miss_cnt_q  <= '0;
         end else begin
            if (fire_oh[w]) begin
               fetch_cnt_q <= fetch_cnt_q + IFETCH_PERF_CNT_W'(1);
            end
            if (miss_hit[w] && miss_sleep) begin
               miss_cnt_q <= miss_cnt_q + IFETCH_PERF_CNT_W'(1);
            end
         end
      end

      assign perf_fetch_cnt[w*IFETCH_PERF_CNT_W +: IFETCH_PERF_CNT_W] = fetch_cnt_q;
      assign perf_miss_cnt[w*IFETCH_PERF_CNT_W +: IFETCH_PERF_CNT_W]  = miss_cnt_q;
   end
`else
   assign perf_fetch_cnt = '0;
   assign perf_miss_cnt  = '0;
`endif

endmodule

// File: doc/ifetch_warp_pc_sched.md
Name: ifetch_warp_pc_sched

Overview:
- Parametrised successor to the ifetch tag stage.
- Holds the per-warp fetch PCs and a per-warp READY/WAIT state.
- Round-robin selects one eligible warp per cycle and presents its PC to the ifetch data stage over a valid/ready handshake. It also drives the icache tag lookup.
- Absorbs miss replay, L2 wake-up and writeback rollback with an explicit replay PC instead of PC-minus-constant arithmetic.

Parameters:
- NUM_WARPS, 4, warps per core (power of 2, >=2); WARP_IDX_W = clog2(NUM_WARPS).
- ADDR_WIDTH, 32, PC width.
- LINE_OFFSET_BITS, 6, log2 of cache line bytes.
- SET_BITS, 6, log2 of L1 icache sets.
- INSTR_BYTES, 4, PC increment per fetch (power of 2).
- RESET_PC, 32'h0, PC of every warp after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- warp_en  in  NUM_WARPS  per-warp enable from csr
- out_valid  out  1  a fetch is offered
- out_ready  in  1  ifetch data stage accepts
- out_pc  out  ADDR_WIDTH  PC of selected warp
- out_warp_idx  out  WARP_IDX_W  selected warp
- icache_fetch_en  out  1  tag lookup strobe (= fire)
- icache_set_idx  out  SET_BITS  out_pc[LINE_OFFSET_BITS+SET_BITS-1:LINE_OFFSET_BITS]
- miss_en  in  1  ifd reports miss or near-miss
- miss_sleep  in  1  qualifies miss_en: 1 = true miss (sleep), 0 = near-miss (replay only)
- miss_warp_idx  in  WARP_IDX_W  missing warp
- miss_pc  in  ADDR_WIDTH  PC to refetch
- wake_bitmap  in  NUM_WARPS  L2 fill completions
- rollback_en  in  1  writeback redirect
- rollback_warp_idx  in  WARP_IDX_W  redirected warp
- rollback_pc  in  ADDR_WIDTH  redirect target
- wait_bitmap  out  NUM_WARPS  warps in WAIT
- perf_fetch_cnt  out  NUM_WARPS*32  per-warp fetch counters, warp 0 in the LSBs
- perf_miss_cnt  out  NUM_WARPS*32  per-warp sleep-miss counters, warp 0 in the LSBs

Behaviour:
- Reset: every PC = RESET_PC, every state = READY, RR pointer = 0.
  - Outputs during and immediately after reset: out_valid=0, icache_fetch_en=0, wait_bitmap=0, counters=0.
  - A reset asserted mid-operation discards all pending state the same cycle.
- Eligible[w] = warp_en[w] & state==READY & ~(miss_en & miss_warp_idx==w) & ~(rollback_en & rollback_warp_idx==w).
- out_valid = |eligible, combinational. Zero cycles from eligibility to offer.
- Selection: first eligible warp at or above the RR pointer, wrapping. out_pc/out_warp_idx come from that warp.
- fire = out_valid & out_ready. icache_fetch_en = fire. icache_set_idx is driven every cycle; it is only meaningful when fire=1.
- On fire: selected PC += INSTR_BYTES, modulo 2^ADDR_WIDTH, so the top PC wraps to 0. RR pointer <= selected+1 mod NUM_WARPS.
- While out_valid & ~out_ready: pointer and PCs hold. Selection changes only if eligibility changes.
- Per-warp update priority, highest first:
  1. rollback: PC <= rollback_pc, state <= READY. This clears WAIT; a late wake is then a no-op.
  2. miss: PC <= miss_pc. state <= WAIT if miss_sleep, else unchanged.
  3. fire on this warp: increment.
  4. hold.
- Wake: state WAIT -> READY when wake_bitmap[w]=1, unless a sleep-miss for w arrives the same cycle. In that case WAIT is kept.
- Wake on a READY warp is ignored.
- Disabled warp (warp_en=0): PC and state hold. Miss, wake and rollback still update it.
- wait_bitmap is registered and reflects current state.
- Latency: a miss/rollback/wake applied at cycle N makes the warp eligible at N+1 at the earliest, with the new PC.

Optional Feature:
- Macro IFETCH_PERF_CNT_EN.
- Defined:
  - perf_fetch_cnt[w] increments on each fire of w.
  - perf_miss_cnt[w] increments on each miss_en & miss_sleep for w.
  - Counters are 32-bit, wrap at 2^32, reset to 0, and are not cleared by rollback.
- Undefined: both ports tied to 0 and no counter flops are built.

Decomposition:
- defines.vh gains:
  - warp state encodings (WARP_READY=1'b0, WARP_WAIT=1'b1);
  - IFETCH_PERF_CNT_W=32;
  - helper localparams for the set-index slice.
- Sub-module ifetch_warp_slot holds one warp's PC register, state flop and the priority update. It is instantiated NUM_WARPS times in a generate loop.
- Arbitration reuses the existing rr_arbiter plus oh_to_idx / idx_to_oh.

Test Plan:
- Reset, NUM_WARPS=4, all enabled, out_ready=1 -> fires warp order 0,1,2,3,0 with PCs 0,0,0,0,4. icache_set_idx=0 throughout.
- out_ready=0 for 3 cycles, then 1 -> out_warp_idx and out_pc held stable, pointer unchanged, one fire on release.
- Sleep-miss for warp 2 with miss_pc=0x40, then wake_bitmap=4'b0100 five cycles later -> warp 2 skipped while waiting and wait_bitmap=4'b0100. Next warp-2 fetch is PC 0x40.
- Same cycle: rollback warp 1 to 0x1000 and miss on warp 1 with miss_pc=0x8 -> PC=0x1000, state READY.
- Sleep-miss and wake on warp 3 in the same cycle -> warp 3 remains in WAIT.
- Warp PC=0xFFFFFFFC fires -> PC wraps to 0x0. With IFETCH_PERF_CNT_EN defined, perf_fetch_cnt for that warp increments by 1.
